// File: rtl/queue_with_controller.sv
// queue_with_controller
//
// Shift-register operand queue for the queue-based calculator, together with
// the occupancy controller that tracks the next write slot.
//
// Every rising edge of clk executes opcode:
//   00 PUSH      : write back at the tail, unless the queue is full
//   01 NOP       : hold
//   10 POP2_PUSH : drop the two front entries, then write back at the new tail
//   11 POP2      : drop the two front entries
//
// Ports
//   clk      : clock, rising-edge active
//   rst      : asynchronous reset, active-low
//   opcode   : operation executed on every rising edge
//   back     : value written by PUSH and POP2_PUSH
//   pos_back : occupancy, equal to the index of the next write slot (0..DEPTH)
//   top_conc : {entry[0], entry[1]}, with the front element in the upper half
//
// Slots that hold no valid entry are always kept at zero. As a result,
// top_conc reads zero in any half whose entry is not valid, and no masking
// is needed.
module queue_with_controller #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 7,
  parameter int PW    = 3
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [1:0]         opcode,
  input  logic [WIDTH-1:0]   back,
  output logic [PW-1:0]      pos_back,
  output logic [2*WIDTH-1:0] top_conc
);

  typedef enum logic [1:0] {
    OP_PUSH      = 2'b00,
    OP_NOP       = 2'b01,
    OP_POP2_PUSH = 2'b10,
    OP_POP2      = 2'b11
  } op_e;

  localparam logic [PW-1:0] FULL = PW'(DEPTH);

  // The occupancy decrement saturates at zero. Popping from a queue that
  // holds fewer than two entries simply empties it.
  function automatic logic [PW-1:0] sat_sub2(input logic [PW-1:0] p);
    return (p < PW'(2)) ? '0 : p - PW'(2);
  endfunction

  // The occupancy increment saturates at DEPTH.
  function automatic logic [PW-1:0] sat_inc(input logic [PW-1:0] p);
    return (p == FULL) ? p : p + PW'(1);
  endfunction

  op_e              op;
  logic [PW-1:0]    pos_nxt;
  logic [PW-1:0]    pos_pop;
  logic [WIDTH-1:0] entry     [DEPTH];
  logic [WIDTH-1:0] entry_nxt [DEPTH];
  logic [WIDTH-1:0] shifted   [DEPTH];

  assign op      = op_e'(opcode);
  assign pos_pop = sat_sub2(pos_back);

  // Controller: next occupancy
  always_comb begin
    pos_nxt = pos_back;
    case (op)
      OP_PUSH:      pos_nxt = sat_inc(pos_back);
      OP_NOP:       pos_nxt = pos_back;
      OP_POP2_PUSH: pos_nxt = sat_inc(pos_pop);
      OP_POP2:      pos_nxt = pos_pop;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) pos_back <= '0;
    else      pos_back <= pos_nxt;
  end

  // Storage: the queue after dropping the two front entries, zero-filled at the top
  always_comb begin
    for (int i = 0; i < DEPTH - 2; i++) shifted[i] = entry[i+2];
    shifted[DEPTH-2] = '0;
    shifted[DEPTH-1] = '0;
  end

  // Write indices come from the pre-edge pos_back. After a pop, the new
  // tail sits at the saturated pos_back-2.
  always_comb begin
    entry_nxt = entry;
    case (op)
      OP_PUSH: begin
        if (pos_back < FULL) entry_nxt[pos_back] = back;
      end
      OP_NOP: entry_nxt = entry;
      OP_POP2_PUSH: begin
        entry_nxt          = shifted;
        entry_nxt[pos_pop] = back;
      end
      OP_POP2: entry_nxt = shifted;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) entry <= '{default: '0};
    else      entry <= entry_nxt;
  end

  assign top_conc = {entry[0], entry[1]};

endmodule

// File: tb/tb_queue_with_controller.sv
module tb_queue_with_controller;

  logic        clk;
  logic        rst;
  logic [1:0]  opcode;
  logic [7:0]  back;
  logic [2:0]  pos_back;
  logic [15:0] top_conc;

  int checks = 0;
  int errors = 0;

  localparam logic [1:0] PUSH = 2'b00, NOP = 2'b01, P2P = 2'b10, POP2 = 2'b11;

  typedef struct {
    logic        rst;
    logic [1:0]  op;
    logic [7:0]  back;
    logic [2:0]  pos;
    logic [15:0] top;
  } vec_t;

  vec_t vecs[$];

  queue_with_controller #(.WIDTH(8), .DEPTH(7), .PW(3)) dut (
    .clk      (clk),
    .rst      (rst),
    .opcode   (opcode),
    .back     (back),
    .pos_back (pos_back),
    .top_conc (top_conc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [2:0] pos_exp, input logic [15:0] top_exp);
    checks++;
    if (pos_back !== pos_exp || top_conc !== top_exp) begin
      errors++;
      $display("FAIL %s: pos_back=%0d top_conc=%h, expected pos_back=%0d top_conc=%h",
               name, pos_back, top_conc, pos_exp, top_exp);
    end
  endtask

  task automatic add(input logic r, input logic [1:0] op, input logic [7:0] b,
                     input logic [2:0] pos, input logic [15:0] top);
    vec_t v;
    v.rst = r; v.op = op; v.back = b; v.pos = pos; v.top = top;
    vecs.push_back(v);
  endtask

  initial begin
    // Hold reset with a mix of opcodes; everything must stay cleared.
    add(0, PUSH, 8'h55, 0, 16'h0000);
    add(0, P2P,  8'hAA, 0, 16'h0000);
    add(0, POP2, 8'h33, 0, 16'h0000);
    // Fill with 1..4.
    add(1, PUSH, 8'd1, 1, 16'h0100);
    add(1, PUSH, 8'd2, 2, 16'h0102);
    add(1, PUSH, 8'd3, 3, 16'h0102);
    add(1, PUSH, 8'd4, 4, 16'h0102);
    // Pop two, then pop two and push 200.
    add(1, POP2, 8'h00, 2, 16'h0304);
    add(1, P2P,  8'd200, 1, 16'hC800);
    add(1, POP2, 8'h00, 0, 16'h0000);
    // POP2_PUSH on an empty queue.
    add(1, P2P,  8'h77, 1, 16'h7700);
    add(1, POP2, 8'h00, 0, 16'h0000);
    // Push 8 values; the 8th is discarded.
    add(1, PUSH, 8'h11, 1, 16'h1100);
    add(1, PUSH, 8'h12, 2, 16'h1112);
    add(1, PUSH, 8'h13, 3, 16'h1112);
    add(1, PUSH, 8'h14, 4, 16'h1112);
    add(1, PUSH, 8'h15, 5, 16'h1112);
    add(1, PUSH, 8'h16, 6, 16'h1112);
    add(1, PUSH, 8'h17, 7, 16'h1112);
    add(1, PUSH, 8'h18, 7, 16'h1112);
    // Pop two, five times, draining past empty.
    add(1, POP2, 8'h00, 5, 16'h1314);
    add(1, POP2, 8'h00, 3, 16'h1516);
    add(1, POP2, 8'h00, 1, 16'h1700);
    add(1, POP2, 8'h00, 0, 16'h0000);
    add(1, POP2, 8'h00, 0, 16'h0000);
    // Build three entries, then NOP for three edges.
    add(1, PUSH, 8'hA1, 1, 16'hA100);
    add(1, PUSH, 8'hB2, 2, 16'hA1B2);
    add(1, PUSH, 8'hC3, 3, 16'hA1B2);
    add(1, NOP,  8'hFF, 3, 16'hA1B2);
    add(1, NOP,  8'hEE, 3, 16'hA1B2);
    add(1, NOP,  8'hDD, 3, 16'hA1B2);
    // POP2_PUSH writes at the old pos_back-2.
    add(1, P2P,  8'h44, 2, 16'hC344);

    rst    = 1'b0;
    opcode = NOP;
    back   = 8'h00;
    @(negedge clk);
    foreach (vecs[i]) begin
      rst    = vecs[i].rst;
      opcode = vecs[i].op;
      back   = vecs[i].back;
      @(negedge clk);
      check($sformatf("vec%0d", i), vecs[i].pos, vecs[i].top);
    end

    // Fill to full, then POP2_PUSH from a full queue.
    opcode = PUSH;
    for (int k = 0; k < 5; k++) begin
      back = 8'(8'h50 + k);
      @(negedge clk);
    end
    check("fill_to_full", 3'd7, 16'hC344);
    opcode = P2P; back = 8'h99;
    @(negedge clk);
    // Remaining entries: 50 51 52 53 54, then 99.
    check("p2p_full", 3'd6, 16'h5051);

    // Pulse reset low between clock edges; the outputs must clear at once.
    opcode = NOP;
    #2 rst = 1'b0;
    #1 check("async_clear", 3'd0, 16'h0000);
    #1 rst = 1'b1;
    @(negedge clk);
    check("after_async", 3'd0, 16'h0000);
    opcode = PUSH; back = 8'h5A;
    @(negedge clk);
    check("push_after_rst", 3'd1, 16'h5A00);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/queue_with_controller.md
# queue_with_controller

Small shift-register queue of 8-bit operands plus its occupancy controller, used as the operand store of the queue-based calculator. The controller tracks the write position (`pos_back`) and the queue stores and shifts data. Every clock edge executes the 2-bit `opcode`. The two front entries are always presented concatenated on `top_conc`, so a downstream ALU can consume a pair of operands and push back a result.

## Interface
Parameters:
- `WIDTH`, 8: data width of one entry.
- `DEPTH`, 7: capacity in entries; `pos_back` counts 0..`DEPTH`.
- `PW`, 3: width of `pos_back`.

Ports:
- `clk` input 1: single clock; all state updates on its rising edge.
- `rst` input 1: reset, asynchronous and active-low.
- `opcode` input 2: operation executed every rising edge.
- `back` input `WIDTH`: value written at the back of the queue by PUSH and POP2_PUSH.
- `pos_back` output `PW`: occupancy, equal to the index of the next write slot. Driven by the controller and consumed by the queue storage.
- `top_conc` output 2*`WIDTH`: {entry[0], entry[1]}, with the front element in bits [15:8].

## Operation
- Storage is entry[0..DEPTH-1], with entry[0] at the front. Valid entries are 0..`pos_back`-1. All invalid entries always hold 0.
- Opcode 00, PUSH:
  - If `pos_back` < `DEPTH`: entry[`pos_back`] <= `back`, and `pos_back` +1.
  - If full: no change.
- Opcode 01, NOP: no change.
- Opcode 10, POP2_PUSH:
  - Drop the two front entries by shifting all entries down by 2, filling the vacated top with 0.
  - Then write `back` at the new tail.
  - `pos_back` <= max(`pos_back`-2, 0) + 1. This is never blocked, because popping two always frees a slot.
- Opcode 11, POP2:
  - Shift all entries down by 2, filling with 0.
  - `pos_back` <= max(`pos_back`-2, 0).
  - With fewer than 2 entries, the queue simply empties.
- `top_conc` is combinational from the registered entries. It reads 0 in the halves whose entries are invalid.
- The controller owns `pos_back` arithmetic, which saturates at 0 and at `DEPTH`. Storage must use the pre-edge `pos_back` as its write index.

## Timing
- Asynchronous reset (`rst`=0): all entries = 0, `pos_back` = 0, `top_conc` = 0. These hold while `rst` is low, regardless of `opcode`.
- Reset mid-operation clears immediately; queue contents are lost.
- Single-cycle latency: `pos_back` and `top_conc` reflect an operation right after the edge that executes it.
- No handshake. The opcode must be stable around each rising edge, and the producer is responsible for driving NOP when idle.

## Test plan
- Reset:
  - Stimulus: drive `rst`=0 with arbitrary `opcode` and `back` over several edges.
  - Required: `pos_back`=0 and `top_conc`=16'h0000 throughout.
- Fill:
  - Stimulus: release reset, then PUSH `back`=1,2,3,4 on four edges.
  - Required: after the edges, `pos_back`=1,2,3,4; `top_conc`=16'h0100, 16'h0102, 16'h0102, 16'h0102.
- Pop two:
  - Stimulus: from that state, POP2.
  - Required: `pos_back`=2 and `top_conc`=16'h0304.
- Pop two and push:
  - Stimulus: next, POP2_PUSH with `back`=200.
  - Required: `pos_back`=1 and `top_conc`=16'hC800.
- Full and underflow:
  - Stimulus: PUSH 8 values into an empty queue.
  - Required: `pos_back` stops at 7 and the 8th value is discarded.
  - Stimulus: then POP2 five times.
  - Required: `pos_back`=5,3,1,0,0 and `top_conc`=0 once empty.
- NOP and async reset:
  - Stimulus: NOP for 3 edges.
  - Required: the state is unchanged.
  - Stimulus: pulse `rst` low between edges.
  - Required: outputs clear immediately, without waiting for a clock edge.
